// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state encoding and defaults for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_DATA = 2'd1;
    localparam arb_state_t ST_INST = 2'd2;
    localparam arb_state_t ST_RESP = 2'd3;

    localparam int unsigned MEM_LAT_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/wait_counter.sv
// ============================================================================
// Module   : wait_counter
// Purpose  : Loadable down-counter with a zero flag for RAM wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one RAM port between fetch and data accesses; data wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              pipe_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_is_data;
    logic              r_drop;
    logic              r_mem_done;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_mem_rdata;
    logic [DATA_W-1:0] r_if_rdata;

    logic w_data_req;
    logic w_fetch_req;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_data_req  = mem_rd | mem_wr;
    assign w_fetch_req = if_req & ~if_flush;
    assign w_cnt_load  = (r_state == ST_IDLE) & (w_data_req | w_fetch_req);
    assign w_cnt_dec   = (r_state == ST_DATA) | (r_state == ST_INST);

    wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (CNT_LOAD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_is_data   <= 1'b0;
            r_drop      <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_valid  <= 1'b0;
            r_mem_rdata <= '0;
            r_if_rdata  <= '0;
        end else begin
            r_mem_done <= 1'b0;
            r_if_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_data_req) begin
                        r_state   <= ST_DATA;
                        r_is_data <= 1'b1;
                        r_is_wr   <= mem_wr;
                        r_addr    <= mem_addr;
                        r_wdata   <= mem_wdata;
                    end else if (w_fetch_req) begin
                        r_state   <= ST_INST;
                        r_is_data <= 1'b0;
                        r_is_wr   <= 1'b0;
                        r_addr    <= if_addr;
                    end
                end
                ST_DATA: begin
                    if (w_cnt_zero) begin
                        r_state     <= ST_RESP;
                        r_mem_done  <= 1'b1;
                        r_mem_rdata <= ram_rdata;
                    end
                end
                ST_INST: begin
                    if (if_flush) begin
                        r_drop <= 1'b1;
                    end
                    // A flush in the final wait cycle must also suppress the pulse.
                    if (w_cnt_zero) begin
                        r_state <= ST_RESP;
                        if (!(r_drop || if_flush)) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= ram_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    if (!r_is_data && if_flush) begin
                        r_drop <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_en    = (r_state == ST_DATA) | (r_state == ST_INST);
    assign ram_we    = (r_state == ST_DATA) & r_is_wr;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;
    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;

    // Stalls are forced low during reset so every output reads zero.
    assign pipe_stall = ~rst & w_data_req & ~r_mem_done;
    assign if_stall   = ~rst & ((if_req & ~r_if_valid) | (w_data_req & ~r_mem_done));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed stimulus with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_flush = 1'b0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              mem_rd = 1'b0;
    logic              mem_wr = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              pipe_stall;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .pipe_stall (pipe_stall),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM (what the DUT talks to) and the model's own memory image.
    logic [DATA_W-1:0] ram_arr [0:4095];
    logic [DATA_W-1:0] ref_mem [0:4095];
    assign ram_rdata = ram_arr[ram_addr[11:0]];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_arr[ram_addr[11:0]] <= ram_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one grant at a time, RAM window g+1..g+L, pulse at g+L+1.
    bit                m_busy = 1'b0;
    int                m_g = 0;
    int                m_idle_at = 0;
    bit                m_data, m_wr, m_drop;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] exp_ird = '0;
    bit                in_win, is_pulse, e_done, e_ifv, e_ps, e_is;

    int                ifv_count = 0, done_count = 0, we_cycles = 0;
    int                last_ifv_cyc = -1, last_done_cyc = -1;
    logic [DATA_W-1:0] last_ifv_data = '0, last_done_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy    = 1'b0;
            m_idle_at = cyc + 1;
            exp_ird   = '0;
            check("rst_ram_en", ram_en, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_mem_done", mem_done, 0);
            check("rst_if_valid", if_valid, 0);
            check("rst_mem_rdata", mem_rdata, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_pipe_stall", pipe_stall, 0);
            check("rst_if_stall", if_stall, 0);
        end else begin
            in_win   = m_busy && (cyc >= m_g + 1) && (cyc <= m_g + int'(MEM_LAT));
            is_pulse = m_busy && (cyc == m_g + int'(MEM_LAT) + 1);
            if (in_win && !m_data && if_flush) m_drop = 1'b1;
            e_done = is_pulse && m_data;
            e_ifv  = is_pulse && !m_data && !m_drop;
            if (e_ifv) exp_ird = ref_mem[m_addr[11:0]];
            if (e_done && m_wr) ref_mem[m_addr[11:0]] = m_wdata;

            check("ram_en", ram_en, in_win);
            check("ram_we", ram_we, in_win && m_data && m_wr);
            if (in_win) check("ram_addr", ram_addr, m_addr);
            if (in_win && m_data && m_wr) check("ram_wdata", ram_wdata, m_wdata);
            check("mem_done", mem_done, e_done);
            check("if_valid", if_valid, e_ifv);
            check("if_rdata", if_rdata, exp_ird);
            if (e_done && !m_wr) check("mem_rdata", mem_rdata, ref_mem[m_addr[11:0]]);
            e_ps = (mem_rd || mem_wr) && !e_done;
            e_is = (if_req && !e_ifv) || e_ps;
            check("pipe_stall", pipe_stall, e_ps);
            check("if_stall", if_stall, e_is);

            if (is_pulse) begin
                m_busy    = 1'b0;
                m_idle_at = cyc + 1;
            end else if (!m_busy && cyc >= m_idle_at) begin
                if (mem_rd || mem_wr) begin
                    m_busy = 1'b1; m_g = cyc; m_data = 1'b1; m_wr = mem_wr;
                    m_addr = mem_addr; m_wdata = mem_wdata; m_drop = 1'b0;
                end else if (if_req && !if_flush) begin
                    m_busy = 1'b1; m_g = cyc; m_data = 1'b0; m_wr = 1'b0;
                    m_addr = if_addr; m_drop = 1'b0;
                end
            end

            if (if_valid) begin
                ifv_count++; last_ifv_cyc = cyc; last_ifv_data = if_rdata;
            end
            if (mem_done) begin
                done_count++; last_done_cyc = cyc; last_done_data = mem_rdata;
            end
            if (ram_we) we_cycles++;
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ifv(input int base);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ifv_count != base) begin
                ok = 1'b1;
                break;
            end
        end
        check("if_valid_timeout", ok, 1);
    endtask

    task automatic wait_done(input int base);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (done_count != base) begin
                ok = 1'b1;
                break;
            end
        end
        check("mem_done_timeout", ok, 1);
    endtask

    int r, base_i, base_d, we0;

    initial begin
        for (int i = 0; i < 4096; i++) ram_arr[i] = 16'(i) ^ 16'h5A5A;
        ram_arr[16'h010] = 16'hABCD;
        ram_arr[16'h020] = 16'hC0DE;
        for (int i = 0; i < 4096; i++) ref_mem[i] = ram_arr[i];

        step(3);
        rst = 1'b0;
        step(2);

        // Single fetch: pulse three cycles after the request.
        r = cyc; base_i = ifv_count;
        if_req = 1'b1; if_addr = 20'h00010;
        wait_ifv(base_i);
        if_req = 1'b0;
        check("t1_ifv_cycle", last_ifv_cyc, r + 3);
        check("t1_ifv_data", last_ifv_data, 16'hABCD);
        step(1);

        // Write: two write-enable cycles, done on the third.
        r = cyc; base_d = done_count; we0 = we_cycles;
        mem_wr = 1'b1; mem_addr = 20'h00100; mem_wdata = 16'h1234;
        wait_done(base_d);
        mem_wr = 1'b0;
        check("t2_done_cycle", last_done_cyc, r + 3);
        check("t2_we_cycles", we_cycles - we0, 2);
        step(1);

        // Readback of the stored word.
        base_d = done_count;
        mem_rd = 1'b1; mem_addr = 20'h00100;
        wait_done(base_d);
        mem_rd = 1'b0;
        check("t3_readback", last_done_data, 16'h1234);
        step(1);

        // Simultaneous requests: data first, fetch four cycles later.
        base_d = done_count; base_i = ifv_count;
        mem_rd = 1'b1; mem_addr = 20'h00010;
        if_req = 1'b1; if_addr = 20'h00020;
        fork
            begin wait_done(base_d); mem_rd = 1'b0; end
            begin wait_ifv(base_i); if_req = 1'b0; end
        join
        check("t4_gap", last_ifv_cyc - last_done_cyc, 4);
        check("t4_data", last_done_data, 16'hABCD);
        check("t4_fetch", last_ifv_data, 16'hC0DE);
        step(1);

        // Data request arriving mid-fetch waits for the fetch to finish.
        base_d = done_count; base_i = ifv_count;
        if_req = 1'b1; if_addr = 20'h00010;
        step(1);
        mem_rd = 1'b1; mem_addr = 20'h00100;
        fork
            begin wait_ifv(base_i); if_req = 1'b0; end
            begin wait_done(base_d); mem_rd = 1'b0; end
        join
        check("t5_order", last_done_cyc - last_ifv_cyc, 4);
        check("t5_fetch", last_ifv_data, 16'hABCD);
        check("t5_data", last_done_data, 16'h1234);
        step(1);

        // Flush mid-fetch: no pulse, fetched word register untouched.
        base_i = ifv_count;
        if_req = 1'b1; if_addr = 20'h00020;
        step(1);
        if_flush = 1'b1;
        step(1);
        if_flush = 1'b0; if_req = 1'b0;
        step(5);
        check("t6_no_valid", ifv_count, base_i);
        check("t6_rdata_held", if_rdata, 16'hABCD);
        if_req = 1'b1; if_addr = 20'h00020;
        wait_ifv(base_i);
        if_req = 1'b0;
        check("t6_refetch", last_ifv_data, 16'hC0DE);
        step(1);

        // Reset in the first data cycle abandons the access.
        base_d = done_count;
        mem_wr = 1'b1; mem_addr = 20'h00030; mem_wdata = 16'hBEEF;
        step(1);
        check("t7_in_data", ram_en, 1);
        rst = 1'b1; mem_wr = 1'b0;
        #1;
        check("t7_ram_en", ram_en, 0);
        check("t7_ram_we", ram_we, 0);
        check("t7_mem_rdata", mem_rdata, 0);
        check("t7_if_rdata", if_rdata, 0);
        step(2);
        rst = 1'b0;
        step(6);
        check("t7_no_done", done_count, base_d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
